// File: rtl/fetch_stage2.sv
// fetch_stage2: instruction extractor behind L1 I-cache fetch stage 1.
//
// Captures one 256-bit cache block per valid/ready handshake and splits it into
// SLOTS 32-bit slots (slot 0 = MSBs). Non-empty slots are emitted one per cycle
// as pre-decoded fields. A set branch bit ends the block early, and a flush drops
// everything in flight.
//
// Ports:
//   clock_i       rising-edge clock
//   reset_i       synchronous, active-low reset
//   block_i       cache block from fetch stage 1
//   enable_i      block_i / blockAddr_i valid
//   blockAddr_i   address of the block on block_i
//   ready_o       block accepted this cycle when enable_i is high (combinational)
//   flush_i       discard the buffered block and the output instruction
//   instrReady_i  decode accepts the current instruction
//   instrValid_o  instruction outputs valid
//   format_o      1 = REG-IMM, 0 = REG-REG
//   branch_o      branch bit
//   opcode_o      opcode
//   primary_o     primary operand register
//   secondary_o   immediate, or zero-extended secondary register
//   pc_o          {block address, slot index} of the emitted instruction
module fetch_stage2 #(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [255:0]                      block_i,
  input  logic                              enable_i,
  input  logic [ADDR_W-1:0]                 blockAddr_i,
  output logic                              ready_o,
  input  logic                              flush_i,
  input  logic                              instrReady_i,
  output logic                              instrValid_o,
  output logic                              format_o,
  output logic                              branch_o,
  output logic [6:0]                        opcode_o,
  output logic [4:0]                        primary_o,
  output logic [15:0]                       secondary_o,
  output logic [ADDR_W+$clog2(SLOTS)-1:0]   pc_o
);

  localparam int unsigned BLOCK_W = 256;
  localparam int unsigned SLOT_W  = BLOCK_W / SLOTS;
  localparam int unsigned IDX_W   = $clog2(SLOTS);
  localparam int unsigned PC_W    = ADDR_W + IDX_W;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  typedef struct packed {
    logic        format;
    logic        branch;
    logic [6:0]  opcode;
    logic [4:0]  primary;
    logic [15:0] secondary;
  } instr_t;

  // Field split of one slot; bits [1:0] (and [12:0] for REG-REG) are ignored.
  function automatic instr_t decode(input logic [SLOT_W-1:0] s);
    instr_t r;
    r.format    = s[31];
    r.branch    = s[30];
    r.opcode    = s[29:23];
    r.primary   = s[22:18];
    r.secondary = s[31] ? s[17:2] : {11'b0, s[17:13]};
    return r;
  endfunction

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [IDX_W-1:0] first_set(input logic [SLOTS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Mask of slot positions strictly after idx.
  function automatic logic [SLOTS-1:0] above(input logic [IDX_W-1:0] idx);
    logic [SLOTS-1:0] m;
    for (int i = 0; i < SLOTS; i++) begin
      m[i] = (i > int'(idx));
    end
    return m;
  endfunction

  // State
  state_e              state_q, state_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SLOTS-1:0]    pending_q, pending_d;  // non-empty slots after the current one
  instr_t              instr_q, instr_d;
  logic [PC_W-1:0]     pc_q, pc_d;

  // Slot views of the incoming and the buffered block
  logic [SLOT_W-1:0]   in_slot  [SLOTS];
  logic [SLOT_W-1:0]   buf_slot [SLOTS];
  logic [SLOTS-1:0]    in_nz;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slots
    assign in_slot[k]  = block_i[BLOCK_W-1-SLOT_W*k -: SLOT_W];
    assign buf_slot[k] = block_q[BLOCK_W-1-SLOT_W*k -: SLOT_W];
    assign in_nz[k]    = |in_slot[k];
  end

  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] next_idx;
  logic             accept;
  logic             is_last;
  logic             capture;

  assign first_idx    = first_set(in_nz);
  assign next_idx     = first_set(pending_q);
  assign instrValid_o = (state_q == StDrain);
  assign accept       = instrValid_o && instrReady_i;
  // A taken branch truncates whatever non-empty slots remain in the block.
  assign is_last      = instr_q.branch || (pending_q == '0);
  assign ready_o      = reset_i && !flush_i && ((state_q == StIdle) || (accept && is_last));
  assign capture      = ready_o && enable_i;

  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    pc_d      = pc_q;

    if (flush_i) begin
      // An instruction accepted alongside the flush is still consumed by decode.
      state_d = StIdle;
    end else if (capture) begin
      block_d = block_i;
      addr_d  = blockAddr_i;
      if (|in_nz) begin
        state_d   = StDrain;
        instr_d   = decode(in_slot[first_idx]);
        pc_d      = {blockAddr_i, first_idx};
        pending_d = in_nz & above(first_idx);
      end else begin
        // Nothing to emit from an all-empty block.
        state_d = StIdle;
      end
    end else if (accept) begin
      if (is_last) begin
        state_d = StIdle;
      end else begin
        // Jump straight to the next non-empty slot; empties cost no cycles.
        instr_d   = decode(buf_slot[next_idx]);
        pc_d      = {addr_q, next_idx};
        pending_d = pending_q & above(next_idx);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      block_q   <= '0;
      addr_q    <= '0;
      pending_q <= '0;
      instr_q   <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
    end
  end

  assign format_o    = instr_q.format;
  assign branch_o    = instr_q.branch;
  assign opcode_o    = instr_q.opcode;
  assign primary_o   = instr_q.primary;
  assign secondary_o = instr_q.secondary;
  assign pc_o        = pc_q;

endmodule
